// File: rtl/ysyx_23060203_mem_arb.sv
// Two-master (IFU/LSU) arbiter onto one single-beat read port.
// One transaction in flight at a time; grant is round-robin or LSU-priority.
module ysyx_23060203_mem_arb #(
    parameter int unsigned RR = 1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic [31:0] ifu_araddr,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,

    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    input  logic [31:0] lsu_araddr,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,

    output logic        s_arvalid,
    input  logic        s_arready,
    output logic [31:0] s_araddr,
    input  logic        s_rvalid,
    output logic        s_rready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      state;
    logic        owner;   // 0 = IFU, 1 = LSU
    logic        last;    // master granted most recently
    logic        in_idle;
    logic        in_data;
    logic        grant_lsu;
    logic        ar_fire;
    logic [31:0] ar_addr;

    // Arready is combinational, so reset also gates it to keep outputs quiet.
    assign in_idle = (state == IDLE) && !reset;
    assign in_data = (state == DATA);

    always_comb begin
        grant_lsu = 1'b0;
        if (lsu_arvalid) begin
            if (!ifu_arvalid)
                grant_lsu = 1'b1;
            else if (RR != 0)
                grant_lsu = ~last;
            else
                grant_lsu = 1'b1;
        end
    end

    assign ifu_arready = in_idle & ifu_arvalid & ~grant_lsu;
    assign lsu_arready = in_idle & grant_lsu;
    assign ar_fire     = ifu_arready | lsu_arready;
    assign ar_addr     = grant_lsu ? lsu_araddr : ifu_araddr;

    // Response path follows the owner; the other master sees nothing.
    assign s_rready   = in_data & (owner ? lsu_rready : ifu_rready);
    assign ifu_rvalid = in_data & ~owner & s_rvalid;
    assign lsu_rvalid = in_data &  owner & s_rvalid;
    assign ifu_rdata  = (in_data & ~owner) ? s_rdata : 32'h0;
    assign lsu_rdata  = (in_data &  owner) ? s_rdata : 32'h0;
    assign ifu_rresp  = (in_data & ~owner) ? s_rresp : 2'b00;
    assign lsu_rresp  = (in_data &  owner) ? s_rresp : 2'b00;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            s_araddr  <= 32'h0;
            s_arvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_fire) begin
                        s_araddr  <= ar_addr;
                        owner     <= grant_lsu;
                        last      <= grant_lsu;
                        s_arvalid <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_arready) begin
                        s_arvalid <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (s_rvalid && s_rready)
                        state <= IDLE;
                end
                default: begin
                    s_arvalid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_mem_arb.sv
// Bench for the IFU/LSU read arbiter: a round-robin and a fixed-priority
// instance share stimulus; expected responses flow through a queue.
module tb_ysyx_23060203_mem_arb;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_arvalid, lsu_arvalid, ifu_rready, lsu_rready;
    logic [31:0] ifu_araddr, lsu_araddr, s_rdata;
    logic        s_arready, s_rvalid;
    logic [1:0]  s_rresp;

    logic        ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, s_arvalid, s_rready;
    logic [31:0] ifu_rdata, lsu_rdata, s_araddr;
    logic [1:0]  ifu_rresp, lsu_rresp;

    logic        fp_ifu_arready, fp_lsu_arready, fp_ifu_rvalid, fp_lsu_rvalid;
    logic        fp_s_arvalid, fp_s_rready;
    logic [31:0] fp_ifu_rdata, fp_lsu_rdata, fp_s_araddr;
    logic [1:0]  fp_ifu_rresp, fp_lsu_rresp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        lsu;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    typedef struct {
        logic        ireq;
        logic        lreq;
        logic [31:0] ia;
        logic [31:0] la;
        logic [31:0] data;
        logic [1:0]  resp;
        int          arw;
        int          rw;
        logic        exp_lsu;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];

    always #5 clock = ~clock;

    ysyx_23060203_mem_arb #(.RR(1)) dut (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
    );

    ysyx_23060203_mem_arb #(.RR(0)) dut_fp (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(fp_ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_rvalid(fp_ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(fp_ifu_rdata), .ifu_rresp(fp_ifu_rresp),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(fp_lsu_arready), .lsu_araddr(lsu_araddr),
        .lsu_rvalid(fp_lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(fp_lsu_rdata), .lsu_rresp(fp_lsu_rresp),
        .s_arvalid(fp_s_arvalid), .s_arready(s_arready), .s_araddr(fp_s_araddr),
        .s_rvalid(s_rvalid), .s_rready(fp_s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        ifu_arvalid = 0; lsu_arvalid = 0; ifu_araddr = 0; lsu_araddr = 0;
        ifu_rready = 0; lsu_rready = 0; s_arready = 0; s_rvalid = 0;
        s_rdata = 0; s_rresp = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic check_resp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_owner_rvalid"}, e.lsu ? lsu_rvalid : ifu_rvalid, 1);
            chk({tag, "_other_rvalid"}, e.lsu ? ifu_rvalid : lsu_rvalid, 0);
            chk({tag, "_rdata"}, e.lsu ? lsu_rdata : ifu_rdata, e.data);
            chk({tag, "_rresp"}, e.lsu ? lsu_rresp : ifu_rresp, e.resp);
            chk({tag, "_s_rready"}, s_rready, 1);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        logic [31:0] addr;
        ifu_arvalid = v.ireq; lsu_arvalid = v.lreq;
        ifu_araddr = v.ia; lsu_araddr = v.la;
        ifu_rready = 0; lsu_rready = 0; s_arready = 0; s_rvalid = 0;
        #1;
        chk("ifu_arready", ifu_arready, !v.exp_lsu);
        chk("lsu_arready", lsu_arready, v.exp_lsu);
        chk("fp_lsu_arready", fp_lsu_arready, v.lreq);
        chk("fp_ifu_arready", fp_ifu_arready, !v.lreq);
        addr = v.exp_lsu ? v.la : v.ia;
        e.lsu = v.exp_lsu; e.addr = addr; e.data = v.data; e.resp = v.resp;
        sb.push_back(e);
        step();
        ifu_arvalid = 0; lsu_arvalid = 0;
        ifu_araddr = 32'hDEAD_BEEF; lsu_araddr = 32'hBAD0_BAD0;
        // Stray slave data while in ADDR must not leak to either master
        s_rvalid = (v.arw > 0); s_rdata = 32'hFFFF_0000;
        #1;
        chk("s_arvalid", s_arvalid, 1);
        chk("s_araddr", s_araddr, addr);
        chk("arready_addr", ifu_arready | lsu_arready, 0);
        for (int i = 0; i < v.arw; i++) begin
            step(); #1;
            chk("s_arvalid_hold", s_arvalid, 1);
            chk("s_araddr_hold", s_araddr, addr);
            chk("rvalid_addr", ifu_rvalid | lsu_rvalid, 0);
        end
        s_rvalid = 0;
        s_arready = 1;
        step();
        s_arready = 0;
        s_rvalid = 1; s_rdata = v.data; s_rresp = v.resp;
        for (int i = 0; i < v.rw; i++) begin
            #1;
            chk("s_rready_wait", s_rready, 0);
            chk("rvalid_wait", v.exp_lsu ? lsu_rvalid : ifu_rvalid, 1);
            chk("rdata_wait", v.exp_lsu ? lsu_rdata : ifu_rdata, v.data);
            chk("arready_data", ifu_arready | lsu_arready, 0);
            step();
        end
        ifu_rready = 1; lsu_rready = 1;
        #1;
        check_resp("vec");
        step();
        #1;
        chk("rvalid_after", ifu_rvalid | lsu_rvalid, 0);
        chk("s_rready_after", s_rready, 0);
        chk("s_arvalid_after", s_arvalid, 0);
        s_rvalid = 0; ifu_rready = 0; lsu_rready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,          32'h1234_5678, 2'b00, 0, 0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h0,          32'h9000_0010, 32'hCAFE_F00D, 2'b10, 0, 0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 32'h8000_0004, 32'h9000_0020, 32'h0000_0001, 2'b00, 0, 0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'h8000_0008, 32'h9000_0030, 32'h0000_0002, 2'b01, 1, 1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'h8000_0010, 32'h0,          32'hA5A5_5A5A, 2'b01, 5, 3, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'h8000_0014, 32'h9000_0040, 32'h0BAD_F00D, 2'b11, 0, 2, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 32'h0,          32'h9000_0050, 32'h7777_8888, 2'b00, 2, 0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 32'h8000_0018, 32'h9000_0060, 32'h1111_2222, 2'b00, 0, 0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 32'h8000_001C, 32'h9000_0070, 32'h3333_4444, 2'b10, 0, 0, 1'b1};

        // Reset state, with requests present to prove arready stays quiet
        idle_inputs();
        reset = 1;
        ifu_arvalid = 1; lsu_arvalid = 1;
        @(negedge clock); #1;
        chk("rst_ifu_arready", ifu_arready, 0);
        chk("rst_lsu_arready", lsu_arready, 0);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_rready", s_rready, 0);
        chk("rst_rvalid", ifu_rvalid | lsu_rvalid, 0);
        chk("rst_s_araddr", s_araddr, 0);
        step();
        idle_inputs();
        reset = 0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Continuous requests from reset with an always-ready slave
        do_reset();
        ifu_arvalid = 1; lsu_arvalid = 1;
        ifu_araddr = 32'h8000_1000; lsu_araddr = 32'h9000_1000;
        s_arready = 1; s_rvalid = 1; s_rdata = 32'h5555_AAAA; s_rresp = 2'b00;
        ifu_rready = 1; lsu_rready = 1;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.lsu = k[0];
            e.addr = e.lsu ? 32'h9000_1000 : 32'h8000_1000;
            e.data = 32'h5555_AAAA; e.resp = 2'b00;
            #1;
            chk("cont_ifu_arready", ifu_arready, !e.lsu);
            chk("cont_lsu_arready", lsu_arready, e.lsu);
            chk("cont_fp_lsu_arready", fp_lsu_arready, 1);
            chk("cont_fp_ifu_arready", fp_ifu_arready, 0);
            sb.push_back(e);
            step(); #1;
            chk("cont_s_arvalid", s_arvalid, 1);
            chk("cont_s_araddr", s_araddr, e.addr);
            chk("cont_fp_s_araddr", fp_s_araddr, 32'h9000_1000);
            chk("cont_arready_addr", ifu_arready | lsu_arready | fp_ifu_arready, 0);
            step(); #1;
            check_resp("cont");
            chk("cont_fp_ifu_rvalid", fp_ifu_rvalid, 0);
            chk("cont_fp_lsu_rvalid", fp_lsu_rvalid, 1);
            step();
        end

        // Reset in the middle of DATA aborts the read
        do_reset();
        ifu_arvalid = 1; ifu_araddr = 32'h8000_2000;
        step();
        ifu_arvalid = 0; s_arready = 1;
        step();
        s_arready = 0; s_rvalid = 1; s_rdata = 32'hFEED_FACE; ifu_rready = 0;
        #1;
        chk("mid_ifu_rvalid", ifu_rvalid, 1);
        reset = 1; ifu_rready = 1;
        #1;
        chk("abort_ifu_rvalid", ifu_rvalid, 0);
        chk("abort_s_rready", s_rready, 0);
        chk("abort_s_arvalid", s_arvalid, 0);
        chk("abort_s_araddr", s_araddr, 0);
        step();
        reset = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("late_rvalid", ifu_rvalid | lsu_rvalid, 0);
            chk("late_s_rready", s_rready, 0);
            chk("late_s_arvalid", s_arvalid, 0);
            step();
        end
        idle_inputs();

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060203_mem_arb.md
YSYX_23060203_MEM_ARB -- requirements
Module: ysyx_23060203_mem_arb

Interface
REQ-001 Parameter: RR, default 1, meaning 1 = round-robin grant, 0 = fixed LSU priority.
REQ-002 Port: clock  in  1  single clock; all state updates on posedge.
REQ-003 Port: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 Port: ifu_arvalid / lsu_arvalid  in  1  master read-address request.
REQ-005 Port: ifu_arready / lsu_arready  out  1  master read-address accept.
REQ-006 Port: ifu_araddr / lsu_araddr  in  32  master read address.
REQ-007 Port: ifu_rvalid / lsu_rvalid  out  1  master read-data valid.
REQ-008 Port: ifu_rready / lsu_rready  in  1  master read-data accept.
REQ-009 Port: ifu_rdata / lsu_rdata  out  32  read data to master.
REQ-010 Port: ifu_rresp / lsu_rresp  out  2  read response to master.
REQ-011 Port: s_arvalid  out  1  shared-port address valid.
REQ-012 Port: s_arready  in  1  shared-port address accept.
REQ-013 Port: s_araddr  out  32  shared-port address.
REQ-014 Port: s_rvalid  in  1  shared-port data valid.
REQ-015 Port: s_rready  out  1  shared-port data accept.
REQ-016 Port: s_rdata  in  32  shared-port read data.
REQ-017 Port: s_rresp  in  2  shared-port read response.

Function
REQ-018 The block SHALL share one single-beat read port between IFU and LSU, with at most one outstanding transaction.
REQ-019 FSM states SHALL be IDLE, ADDR, DATA; grant register owner (0 = IFU, 1 = LSU); last-grant register last.
REQ-020 In IDLE with exactly one arvalid high, that master SHALL be granted.
REQ-021 In IDLE with both high, RR=1: grant the master not equal to last; RR=0: grant LSU.
REQ-022 In IDLE, arready SHALL be asserted combinationally to the granted master only; the other master's arready SHALL stay 0.
REQ-023 On master AR handshake: latch araddr into s_araddr register, set owner, set last = owner, go to ADDR.
REQ-024 In ADDR, s_arvalid SHALL be 1 and s_araddr stable; on s_arready go to DATA, else hold (no timeout).
REQ-025 Latency: s_arvalid SHALL assert exactly one cycle after the master AR handshake.
REQ-026 In DATA, s_rvalid/s_rdata/s_rresp SHALL route combinationally to the owner; the non-owner's rvalid SHALL be 0.
REQ-027 In DATA, s_rready SHALL equal the owner's rready; on s_rvalid & s_rready go to IDLE.
REQ-028 Outside DATA, s_rready and both master rvalid SHALL be 0; s_rvalid outside DATA SHALL be ignored.
REQ-029 New arbitration SHALL NOT occur in the DATA completion cycle; next grant is in the following IDLE cycle (min 3 cycles per transaction).
REQ-030 arready to both masters SHALL be 0 in ADDR and DATA.
REQ-031 rresp SHALL pass unchanged, including error codes; the block SHALL NOT retry.
REQ-032 A master dropping arvalid while not granted SHALL lose no state; last SHALL update only on an actual grant.

Reset
REQ-033 On reset: state = IDLE, owner = 0, last = 1 (IFU wins the first tie), s_araddr = 0, all outputs valid/ready = 0.
REQ-034 Reset asserted in ADDR or DATA SHALL abort the transaction immediately; no response SHALL be delivered after release.

Verification
REQ-035 Only IFU requests 0x8000_0000, s_arready=1, s_rvalid next cycle with rdata 0x1234_5678 -> ifu_rdata=0x1234_5678, lsu_rvalid=0 throughout.
REQ-036 RR=1, both request continuously from reset -> grants IFU, LSU, IFU, LSU, each transaction 3 cycles with immediate slave.
REQ-037 RR=0, both request continuously -> LSU granted every time, IFU starved, ifu_arready=0.
REQ-038 s_arready held low 5 cycles -> s_arvalid high and s_araddr stable 5 cycles, no state change; owner rready low 3 cycles in DATA -> s_rready low, data held.
REQ-039 s_rresp=2'b10 for LSU read -> lsu_rresp=2'b10, FSM returns to IDLE.
REQ-040 Reset asserted mid-DATA -> outputs 0 within the same cycle, IDLE after release, late s_rvalid ignored.
